// File: rtl/arb_pkg.sv
// Shared constants, state encoding and small helpers for the 4-way round-robin
// bus arbiter (bus_arbiter_rr4) and its picker (rr_pick4).
package arb_pkg;

   localparam int NUM_REQ    = 4;
   localparam int SEL_W      = 2;
   // Wide enough for the largest turnaround length (15 dead cycles).
   localparam int TURN_CNT_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_TURN  = 2'd2
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit scanning from ptr
// upward modulo 4, plus an any-request flag.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   winner,
   output logic               any
);

   // rot[k] is the request that sits k positions after the pointer.
   logic [NUM_REQ-1:0] rot;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign rot[gi] = req[ptr + SEL_W'(gi)];
      end
   endgenerate

   always_comb begin
      winner = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            winner = ptr + SEL_W'(k);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Round-robin owner arbitration for a shared 4:1 mux / tristate path with dead
// cycles between owners. Define ARB_TIMEOUT_EN to build hold-timeout preemption.
module bus_arbiter_rr4
   import arb_pkg::*;
#(
   parameter int TURN_CYCLES = 1,
   parameter int MAX_HOLD    = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               en,
   output logic               busy
);

   localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURN_CYCLES - 1);

   arb_state_e            state_q;
   logic [NUM_REQ-1:0]    gnt_q;
   logic [SEL_W-1:0]      sel_q;
   logic [SEL_W-1:0]      ptr_q;
   logic                  en_q;
   logic                  busy_q;
   logic [TURN_CNT_W-1:0] turn_cnt_q;

   logic [SEL_W-1:0]      winner;
   logic                  any_req;
   logic                  owner_release;
   logic                  preempt;
   logic                  leave_grant;
   logic                  start_grant;

   rr_pick4 u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (winner),
      .any    (any_req)
   );

   assign owner_release = ~req[sel_q];

`ifdef ARB_TIMEOUT_EN
   localparam int                    HOLD_CNT_W = 8;
   localparam logic [HOLD_CNT_W-1:0] HOLD_SAT   = HOLD_CNT_W'(MAX_HOLD);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST  = HOLD_CNT_W'(MAX_HOLD - 1);

   logic [HOLD_CNT_W-1:0] hold_q;
   logic [HOLD_CNT_W-1:0] hold_d;
   logic                  others_waiting;

   assign others_waiting = |(req & ~gnt_q);
   assign hold_d         = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
   // hold_q counts completed grant cycles, so HOLD_LAST marks the final one.
   assign preempt        = (hold_q >= HOLD_LAST) && others_waiting;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
      end else if (state_q == ARB_GRANT) begin
         hold_q <= hold_d;
      end else begin
         hold_q <= '0;
      end
   end
`else
   logic unused_max_hold;

   assign preempt         = 1'b0;
   assign unused_max_hold = (MAX_HOLD != 0);
`endif

   // Release and timeout both lead to the same single TURN sequence.
   assign leave_grant = owner_release | preempt;
   assign start_grant = any_req &&
                        ((state_q == ARB_IDLE) ||
                         (state_q == ARB_TURN && turn_cnt_q == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         gnt_q      <= '0;
         sel_q      <= '0;
         ptr_q      <= '0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         turn_cnt_q <= '0;
      end else if (start_grant) begin
         state_q <= ARB_GRANT;
         sel_q   <= winner;
         gnt_q   <= onehot(winner);
         ptr_q   <= winner + 1'b1;
         en_q    <= 1'b1;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ARB_GRANT: begin
               if (leave_grant) begin
                  state_q    <= ARB_TURN;
                  gnt_q      <= '0;
                  en_q       <= 1'b0;
                  turn_cnt_q <= TURN_LOAD;
               end
            end
            ARB_TURN: begin
               if (turn_cnt_q != '0) begin
                  turn_cnt_q <= turn_cnt_q - 1'b1;
               end else begin
                  state_q <= ARB_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ARB_IDLE: begin
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= ARB_IDLE;
               gnt_q   <= '0;
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign en   = en_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Bench for bus_arbiter_rr4: directed scenarios and random requests checked
// against an owner / dead-gap reference model.
module tb_bus_arbiter_rr4;

   localparam int TC = 1;
   localparam int MH = 8;
`ifdef ARB_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       en;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: current owner (-1 = none), last owner, priority start, dead cycles left, cycles held.
   int m_owner, m_last, m_ptr, m_dead, m_held;

   always #5 clk = ~clk;

   bus_arbiter_rr4 #(
      .TURN_CYCLES (TC),
      .MAX_HOLD    (MH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .gnt  (gnt),
      .sel  (sel),
      .en   (en),
      .busy (busy)
   );

   function automatic logic [3:0] exp_gnt();
      return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
   endfunction

   function automatic logic [1:0] exp_sel();
      return 2'(m_last);
   endfunction

   function automatic logic exp_en();
      return (m_owner >= 0);
   endfunction

   function automatic logic exp_busy();
      return (m_owner >= 0) || (m_dead > 0);
   endfunction

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_dead  = 0;
      m_held  = 0;
   endtask

   task automatic model_edge(input logic [3:0] r);
      bit arb;
      arb = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner] ||
             (TIMEOUT_ON && m_held >= MH && (r & ~(4'b0001 << m_owner)) != 4'b0000)) begin
            m_owner = -1;
            m_dead  = TC;
         end else begin
            m_held++;
         end
      end else if (m_dead > 0) begin
         m_dead--;
         arb = (m_dead == 0);
      end else begin
         arb = 1'b1;
      end
      if (arb) begin
         for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (r[idx] && m_owner < 0) begin
               m_owner = idx;
               m_last  = idx;
               m_ptr   = (idx + 1) % 4;
               m_held  = 1;
               $display("t=%0t grant req=%b -> owner %0d", $time, r, idx);
            end
         end
      end
   endtask

   task automatic tick(input logic [3:0] r);
      @(negedge clk);
      req = r;
      @(posedge clk);
      model_edge(r);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0000;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      tick(4'b0000);
   endtask

   task automatic settle();
      repeat (TC + 3) tick(4'b0000);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b0000;
      model_reset();
      #12;
      n_cmp++;
      if ({gnt, sel, en, busy} !== 8'b0) begin
         n_bad++;
         $display("FAIL reset_outputs gnt=%b sel=%b en=%b busy=%b required all zero", gnt, sel, en, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({gnt, en, busy} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_release gnt=%b en=%b busy=%b required zero", gnt, en, busy);
      end
   endtask

   task automatic test_first_grant();
      tick(4'b0000);
      tick(4'b0000);
      tick(4'b0010);
      n_cmp++;
      if (gnt !== 4'b0010 || sel !== 2'd1 || en !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL first_grant gnt=%b sel=%0d en=%b busy=%b required gnt=0010 sel=1 en=1 busy=1", gnt, sel, en, busy);
      end
      tick(4'b0000);
      n_cmp++;
      if (en !== 1'b0 || gnt !== 4'b0000 || sel !== 2'd1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL release gnt=%b sel=%0d en=%b busy=%b required gnt=0000 sel=1 en=0 busy=1", gnt, sel, en, busy);
      end
      // Pointer now 2: of 0111, requester 2 wins.
      tick(4'b0111);
      n_cmp++;
      if (gnt !== 4'b0100 || sel !== 2'd2) begin
         n_bad++;
         $display("FAIL ptr_after_first gnt=%b sel=%0d required gnt=0100 sel=2", gnt, sel);
      end
      settle();
   endtask

   task automatic test_rotation();
      logic [3:0] r;
      logic [3:0] prev;
      int order[$];
      int gaps[$];
      int gap;
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};
      do_reset();
      prev = gnt;
      gap  = 0;
      for (int c = 0; c < 80 && order.size() < 5; c++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_held >= 3) r[m_owner] = 1'b0;
         tick(r);
         n_cmp++;
         if ({gnt, sel, en, busy} !== {exp_gnt(), exp_sel(), exp_en(), exp_busy()}) begin
            n_bad++;
            $display("FAIL rotation_cycle c=%0d gnt=%b sel=%0d en=%b busy=%b required gnt=%b sel=%0d en=%b busy=%b",
                     c, gnt, sel, en, busy, exp_gnt(), exp_sel(), exp_en(), exp_busy());
         end
         if (gnt == 4'b0000) begin
            gap++;
         end else if (prev == 4'b0000) begin
            order.push_back(oh_idx(gnt));
            if (order.size() > 1) gaps.push_back(gap);
            gap = 0;
         end
         prev = gnt;
      end
      n_cmp++;
      if (order.size() != 5) begin
         n_bad++;
         $display("FAIL rotation_count grants=%0d required 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (order[i] != exp_order[i]) begin
               n_bad++;
               $display("FAIL rotation_order i=%0d owner=%0d required %0d", i, order[i], exp_order[i]);
            end
         end
         foreach (gaps[i]) begin
            n_cmp++;
            if (gaps[i] != TC) begin
               n_bad++;
               $display("FAIL rotation_gap i=%0d dead=%0d required %0d", i, gaps[i], TC);
            end
         end
      end
      settle();
   endtask

   task automatic test_ptr_wrap();
      do_reset();
      tick(4'b0100);
      tick(4'b0000);
      tick(4'b1001);
      n_cmp++;
      if (gnt !== 4'b1000 || sel !== 2'd3 || en !== 1'b1) begin
         n_bad++;
         $display("FAIL ptr_wrap_first gnt=%b sel=%0d en=%b required gnt=1000 sel=3 en=1", gnt, sel, en);
      end
      tick(4'b0001);
      n_cmp++;
      if (gnt !== 4'b0000 || en !== 1'b0 || sel !== 2'd3) begin
         n_bad++;
         $display("FAIL ptr_wrap_dead gnt=%b en=%b sel=%0d required gnt=0000 en=0 sel=3", gnt, en, sel);
      end
      tick(4'b0001);
      n_cmp++;
      if (gnt !== 4'b0001 || sel !== 2'd0) begin
         n_bad++;
         $display("FAIL ptr_wrap_second gnt=%b sel=%0d required gnt=0001 sel=0", gnt, sel);
      end
      settle();
   endtask

   task automatic test_random();
      logic [3:0] r;
      r = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 99) < 25) r[b] = ~r[b];
         tick(r);
         n_cmp++;
         if ({gnt, sel, en, busy} !== {exp_gnt(), exp_sel(), exp_en(), exp_busy()}) begin
            n_bad++;
            $display("FAIL random c=%0d req=%b gnt=%b sel=%0d en=%b busy=%b required gnt=%b sel=%0d en=%b busy=%b",
                     c, r, gnt, sel, en, busy, exp_gnt(), exp_sel(), exp_en(), exp_busy());
         end
      end
      settle();
   endtask

   task automatic test_hold_lone();
      settle();
      tick(4'b0001);
      for (int c = 0; c < 20; c++) begin
         tick(4'b0001);
         n_cmp++;
         if (gnt !== 4'b0001 || en !== 1'b1 || gnt !== exp_gnt()) begin
            n_bad++;
            $display("FAIL hold_lone c=%0d gnt=%b en=%b required gnt=0001 en=1", c, gnt, en);
         end
      end
      settle();
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int held;
      settle();
      tick(4'b0001);
      held = (gnt == 4'b0001) ? 1 : 0;
      tick(4'b0001);
      if (gnt == 4'b0001) held++;
      for (int c = 0; c < 30 && gnt == 4'b0001; c++) begin
         tick(4'b0101);
         n_cmp++;
         if ({gnt, en, busy} !== {exp_gnt(), exp_en(), exp_busy()}) begin
            n_bad++;
            $display("FAIL timeout_cycle c=%0d gnt=%b en=%b busy=%b required gnt=%b en=%b busy=%b",
                     c, gnt, en, busy, exp_gnt(), exp_en(), exp_busy());
         end
         if (gnt == 4'b0001) held++;
      end
      n_cmp++;
      if (held != MH) begin
         n_bad++;
         $display("FAIL timeout_hold held=%0d required %0d", held, MH);
      end
      n_cmp++;
      if (gnt !== 4'b0000 || en !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_dead gnt=%b en=%b required gnt=0000 en=0", gnt, en);
      end
      tick(4'b0101);
      n_cmp++;
      if (gnt !== 4'b0100 || en !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_next gnt=%b en=%b required gnt=0100 en=1", gnt, en);
      end
      settle();
   endtask
`else
   task automatic test_no_preempt();
      settle();
      tick(4'b0001);
      for (int c = 0; c < 20; c++) begin
         tick(4'b0101);
         n_cmp++;
         if (gnt !== 4'b0001 || en !== 1'b1) begin
            n_bad++;
            $display("FAIL no_preempt c=%0d gnt=%b en=%b required gnt=0001 en=1", c, gnt, en);
         end
      end
      settle();
   endtask
`endif

   task automatic test_async_reset();
      settle();
      tick(4'b0001);
      n_cmp++;
      if (gnt !== 4'b0001 || en !== 1'b1) begin
         n_bad++;
         $display("FAIL async_pre gnt=%b en=%b required gnt=0001 en=1", gnt, en);
      end
      #2;
      rst = 1'b1;
      req = 4'b0000;
      #1;
      n_cmp++;
      if (gnt !== 4'b0000 || en !== 1'b0 || busy !== 1'b0 || sel !== 2'd0) begin
         n_bad++;
         $display("FAIL async_reset gnt=%b en=%b busy=%b sel=%0d required all zero", gnt, en, busy, sel);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      tick(4'b1111);
      n_cmp++;
      if (gnt !== 4'b0001 || sel !== 2'd0 || en !== 1'b1) begin
         n_bad++;
         $display("FAIL async_restart gnt=%b sel=%0d en=%b required gnt=0001 sel=0 en=1", gnt, sel, en);
      end
      settle();
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_rotation();
      test_ptr_wrap();
      test_random();
      test_hold_lone();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_preempt();
`endif
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr4.md
# bus_arbiter_rr4

Round-robin arbiter that shares the 4:1 mux/decoder/tristate-buffer output path between four requesters. It turns per-requester `req` lines into a one-hot grant plus the `sel`/`en` controls of the shared path. It inserts configurable dead (turnaround) cycles between owners so two drivers never overlap on the tristate output. An optional hold-timeout preempts an owner that keeps the path too long while others wait.

## Interface
Parameters:
- `TURN_CYCLES`, default 1: number of dead cycles (`en`=0) between successive owners; legal range 1–15.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before preemption; used only with `ARB_TIMEOUT_EN`; legal range 2–255.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  request per requester; bit i maps to mux input i.
- `gnt`  out  4  one-hot grant; all zeros when no owner.
- `sel`  out  2  mux select, equal to the index of the current owner.
- `en`  out  1  tristate-buffer enable; high only while `gnt` is non-zero.
- `busy`  out  1  high in the GRANT and TURN states.

## Operation
- Three states:
  - IDLE: `en`=0, `gnt`=0.
  - GRANT: `en`=1, `gnt`=onehot(`sel`).
  - TURN: `en`=0, `gnt`=0.
- Priority pointer `ptr` (2 bits). The winner is the first set bit of `req` scanning `ptr`, `ptr`+1, … modulo 4. On every grant, `ptr` ← winner+1 modulo 4 (3 wraps to 0).
- Transitions:
  - IDLE → GRANT when `req`≠0; `sel` is loaded with the winner.
  - GRANT → TURN when `req[sel]`=0 (the owner releases).
  - GRANT → TURN on timeout (see Configuration).
  - TURN stays for `TURN_CYCLES` cycles, then re-arbitrates. If `req`≠0 it goes to GRANT with the new winner, otherwise to IDLE.
- A released owner that re-raises `req` during TURN is arbitrated normally. It has lowest priority because `ptr` has moved past it.
- The hold counter clears on entry to GRANT, increments each GRANT cycle and saturates at `MAX_HOLD`.
- `sel` holds its last value in IDLE and TURN. Only `en` gates the output.
- Requests that change during GRANT have no effect on `sel`.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `gnt`=0, `sel`=0, `en`=0, `busy`=0, `ptr`=0, hold counter=0.
- Grant latency: `req` sampled high at edge k in IDLE → `gnt`/`en` high from edge k.
- Release latency: owner `req` sampled low at edge k → `en`=0 from edge k.
- Next owner: `en` is high again after exactly `TURN_CYCLES` low cycles.
- `en`=1 never persists across an owner change, so the two drivers never overlap.
- Reset asserted mid-grant: `en`, `gnt` and `busy` drop asynchronously, without waiting for an edge. After release, arbitration restarts from `ptr`=0.
- Release and timeout in the same cycle: release takes precedence. Both lead to TURN, and only one TURN sequence is entered.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - In GRANT, if the hold counter has reached `MAX_HOLD` and any other `req` bit is set, go to TURN even though the owner still requests.
  - The owner keeps `gnt` for exactly `MAX_HOLD` cycles.
  - If no other requester is waiting, the owner keeps the grant indefinitely.
- `ARB_TIMEOUT_EN` undefined:
  - No hold counter is built.
  - The owner keeps the grant until it drops `req`.
  - `MAX_HOLD` is ignored.

## Structure
- Shared package `arb_pkg` holds:
  - `NUM_REQ`=4 and `SEL_W`=2.
  - The state enum: `ARB_IDLE`, `ARB_GRANT`, `ARB_TURN`.
  - The turnaround counter width constant.
- Sub-module `rr_pick4`: a combinational picker. It takes `req[3:0]` and `ptr[1:0]` and returns `winner[1:0]` plus `any`. It is instantiated once.
- The top level contains the FSM, `ptr`, and the turnaround and hold counters.

## Test plan
- Reset, then `req`=0010 sampled at edge 3 → `gnt`=0010, `sel`=01, `en`=1 from edge 3; `ptr`=2.
- `req`=1111 held, each owner drops its bit 3 cycles after its grant, `TURN_CYCLES`=1 → grant order 0,1,2,3,0 with exactly one `en`=0 cycle between owners.
- `ptr`=3 (after a grant to 2), `req`=1001 → `gnt`=1000 first, then `gnt`=0001 after TURN.
- With `ARB_TIMEOUT_EN`, `MAX_HOLD`=8: `req0` held, `req2` raised in the owner's second cycle → `gnt`=0001 for exactly 8 cycles, 1 dead cycle, then `gnt`=0100.
- With `ARB_TIMEOUT_EN`: only `req0` held for 20 cycles → `en` stays 1 and `gnt`=0001 for all 20 cycles.
- `rst` pulsed mid-GRANT between clock edges → `en`/`gnt`/`busy`=0 before the next edge; after release, `req`=1111 → `gnt`=0001.
